// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 master bridge and its helpers.
// The response flag positions are used by the bridge to pack error/timeout flags.
package apb3_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int RSP_ERR_BIT = 0;
  localparam int RSP_TMO_BIT = 1;
  localparam int RSP_FLAG_W  = 2;

  // A limit of 0 still needs a one-bit counter so the ports stay legal.
  function automatic int cnt_width(input int limit);
    if (limit < 1) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb3_timeout_counter.sv
// Saturating wait counter for bus masters: clear has priority, counts on enable.
// o_last flags that one more enabled cycle reaches LIMIT; LIMIT=0 keeps both flags low.
module apb3_timeout_counter
  import apb3_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last,
  output logic o_expired
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] SAT = (LIMIT == 0) ? {W{1'b1}} : W'(LIMIT);
  localparam logic [W-1:0] PRE = SAT - 1'b1;

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != SAT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_last    = (LIMIT != 0) && (r_count == PRE);
  assign o_expired = (LIMIT != 0) && (r_count == SAT);

endmodule

// File: rtl/apb3_master_bridge.sv
// APB3 initiator: one valid/ready command becomes one SETUP/ACCESS transfer, result on a held response.
// Accept at N, PSEL at N+1, PENABLE at N+2, rsp_valid at N+3 or later; cmd_ready low until response taken.
module apb3_master_bridge
  import apb3_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  io_apb_PCLK,
  input  logic                  io_apb_PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] io_apb_PADDR,
  output logic [0:0]            io_apb_PSEL,
  output logic                  io_apb_PENABLE,
  output logic                  io_apb_PWRITE,
  output logic [DATA_WIDTH-1:0] io_apb_PWDATA,
  input  logic                  io_apb_PREADY,
  input  logic [DATA_WIDTH-1:0] io_apb_PRDATA,
  input  logic                  io_apb_PSLVERROR
);

  state_t                  r_state;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [RSP_FLAG_W-1:0]   r_rsp_flags;

  logic w_accept;
  logic w_cnt_clear;
  logic w_cnt_enable;
  logic w_cnt_last;
  logic w_cnt_expired;
  logic w_abort;

  assign w_accept     = (r_state == IDLE) && cmd_valid;
  assign w_cnt_clear  = w_accept;
  assign w_cnt_enable = (r_state == ACCESS) && !io_apb_PREADY;
  // Abort only on a wait cycle, so a PREADY in the trigger cycle still completes.
  assign w_abort      = w_cnt_enable && (w_cnt_last || w_cnt_expired);

  apb3_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .i_clk     (io_apb_PCLK),
    .i_rst     (io_apb_PRESET),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_last    (w_cnt_last),
    .o_expired (w_cnt_expired)
  );

  always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
    if (io_apb_PRESET) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
            r_pwrite <= cmd_write;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (io_apb_PREADY) begin
            r_rsp_rdata              <= r_pwrite ? '0 : io_apb_PRDATA;
            r_rsp_flags[RSP_ERR_BIT] <= io_apb_PSLVERROR;
            r_rsp_flags[RSP_TMO_BIT] <= 1'b0;
            r_psel                   <= 1'b0;
            r_penable                <= 1'b0;
            r_rsp_valid              <= 1'b1;
            r_state                  <= RESP;
          end else if (w_abort) begin
            r_rsp_rdata              <= '0;
            r_rsp_flags[RSP_ERR_BIT] <= 1'b1;
            r_rsp_flags[RSP_TMO_BIT] <= 1'b1;
            r_psel                   <= 1'b0;
            r_penable                <= 1'b0;
            r_rsp_valid              <= 1'b1;
            r_state                  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = (r_state == IDLE);
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_error      = r_rsp_flags[RSP_ERR_BIT];
  assign rsp_timeout    = r_rsp_flags[RSP_TMO_BIT];
  assign io_apb_PADDR   = r_paddr;
  assign io_apb_PSEL    = r_psel;
  assign io_apb_PENABLE = r_penable;
  assign io_apb_PWRITE  = r_pwrite;
  assign io_apb_PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Bench for apb3_master_bridge: directed vector table, reset corner cases, then random transfers vs a transaction model.
module tb_apb3_master_bridge;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic [0:0]    psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverror = 1'b0;

  always #5 clk = ~clk;

  apb3_master_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .io_apb_PCLK      (clk),
    .io_apb_PRESET    (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .rsp_timeout      (rsp_timeout),
    .io_apb_PADDR     (paddr),
    .io_apb_PSEL      (psel),
    .io_apb_PENABLE   (penable),
    .io_apb_PWRITE    (pwrite),
    .io_apb_PWDATA    (pwdata),
    .io_apb_PREADY    (pready),
    .io_apb_PRDATA    (prdata),
    .io_apb_PSLVERROR (pslverror)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rdata;
    bit            err;
    int            rdly;
    logic [DW-1:0] e_rdata;
    bit            e_err;
    bit            e_tmo;
    int            e_lat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a slave that never answers within TMO ACCESS cycles times out.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.waits >= TMO) begin
      r.e_rdata = '0;
      r.e_err   = 1'b1;
      r.e_tmo   = 1'b1;
      r.e_lat   = 2 + TMO;
    end else begin
      r.e_rdata = v.wr ? '0 : v.rdata;
      r.e_err   = v.err;
      r.e_tmo   = 1'b0;
      r.e_lat   = 3 + v.waits;
    end
    return r;
  endfunction

  // Called in an IDLE cycle; returns in the first cycle after the response handshake.
  task automatic run_txn(input vec_t v);
    int            lat;
    logic [48:0]   exp_bus;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    rsp_ready = 1'b0;
    exp_bus   = {v.wr, v.addr, v.wdata};
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    lat = 40;
    for (int c = 1; c < 40; c++) begin
      tick();
      // A new command held during the transfer must not disturb it.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      pready    = 1'b0;
      prdata    = DW'($urandom);
      pslverror = 1'($urandom);
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (c == 1) chk("setup_phase", 64'({cmd_ready, psel, penable}), 64'b010);
      else        chk("access_phase", 64'({cmd_ready, psel, penable}), 64'b011);
      chk("apb_bus_stable", 64'({pwrite, paddr, pwdata}), 64'(exp_bus));
      if (c >= 2 && (c - 2) == v.waits) begin
        pready    = 1'b1;
        prdata    = v.rdata;
        pslverror = v.err;
      end
    end
    cmd_valid = 1'b0;
    pready    = 1'b0;
    chk("rsp_latency", 64'(lat), 64'(v.e_lat));
    for (int d = 0; d <= v.rdly; d++) begin
      chk("rsp_hold", 64'({rsp_valid, rsp_rdata, rsp_error, rsp_timeout, cmd_ready, psel, penable}),
          64'({1'b1, v.e_rdata, v.e_err, v.e_tmo, 3'b000}));
      rsp_ready = (d == v.rdly);
      tick();
    end
    rsp_ready = 1'b0;
    chk("after_handshake", 64'({rsp_valid, cmd_ready, psel}), 64'b010);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;

    vecs[0] = '{1'b0, 16'h1004, 32'h0,        0, 32'hDEADBEEF, 1'b0, 0,  32'hDEADBEEF, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b1, 16'h0008, 32'h12345678, 3, 32'hFFFF0000, 1'b0, 0,  32'h0,        1'b0, 1'b0, 6};
    vecs[2] = '{1'b0, 16'h0020, 32'h0,        1, 32'hA5A50001, 1'b1, 1,  32'hA5A50001, 1'b1, 1'b0, 4};
    vecs[3] = '{1'b0, 16'h0030, 32'h0,        9, 32'h55555555, 1'b0, 0,  32'h0,        1'b1, 1'b1, 6};
    vecs[4] = '{1'b1, 16'h0034, 32'hCAFEF00D, 4, 32'h77777777, 1'b0, 2,  32'h0,        1'b1, 1'b1, 6};
    vecs[5] = '{1'b0, 16'h0038, 32'h0,        3, 32'h0BADF00D, 1'b0, 0,  32'h0BADF00D, 1'b0, 1'b0, 6};
    vecs[6] = '{1'b0, 16'h0040, 32'h0,        0, 32'h11223344, 1'b0, 10, 32'h11223344, 1'b0, 1'b0, 3};
    vecs[7] = '{1'b1, 16'h0044, 32'h99887766, 0, 32'h12121212, 1'b1, 0,  32'h0,        1'b1, 1'b0, 3};

    // Reset state
    tick();
    tick();
    chk("reset_flags", 64'({psel, penable, pwrite, rsp_valid, rsp_error, rsp_timeout}), 64'd0);
    chk("reset_bus", 64'({paddr, pwdata}), 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 64'({cmd_ready, rsp_valid}), 64'b10);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in the middle of ACCESS: outputs drop without a clock edge, no response follows.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0050;
    cmd_wdata = 32'h0F0F0F0F;
    pready    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_reset_access", 64'({psel, penable}), 64'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_ctrl", 64'({psel, penable, rsp_valid, pwrite}), 64'd0);
    chk("async_reset_bus", 64'({paddr, pwdata}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("ready_after_midreset", 64'(cmd_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_rsp_after_reset", 64'({rsp_valid, psel, cmd_ready}), 64'b001);
    end

    for (int n = 0; n < 40; n++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = AW'($urandom);
      v.wdata = DW'($urandom);
      v.waits = $urandom_range(0, 6);
      v.rdata = DW'($urandom);
      v.err   = 1'($urandom_range(0, 1));
      v.rdly  = $urandom_range(0, 3);
      v       = model(v);
      run_txn(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/apb3_master_bridge.md
Name: apb3_master_bridge

Overview:
Initiator end of the APB3 bus: converts a simple valid/ready command stream (from a CPU-side or debug host) into APB3 SETUP/ACCESS transfers. It drives the same APB3 signal set that the USART peripheral router consumes. It returns read data, slave error and a timeout flag on a valid/ready response channel. One transfer is outstanding at a time; a watchdog aborts transfers whose slave never asserts PREADY.

Parameters:
ADDR_WIDTH, 16, APB address width (PADDR and cmd_addr)
DATA_WIDTH, 32, APB data width (PWDATA/PRDATA, cmd_wdata/rsp_rdata)
TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for PREADY; 0 disables timeout

Ports:
io_apb_PCLK  in  1  clock
io_apb_PRESET  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_error  out  1  PSLVERROR seen or timeout
rsp_timeout  out  1  transfer aborted by watchdog
io_apb_PADDR  out  ADDR_WIDTH  APB address
io_apb_PSEL  out  1  APB select (single slave-select bit, [0:0])
io_apb_PENABLE  out  1  APB enable
io_apb_PWRITE  out  1  APB direction
io_apb_PWDATA  out  DATA_WIDTH  APB write data
io_apb_PREADY  in  1  slave ready
io_apb_PRDATA  in  DATA_WIDTH  slave read data
io_apb_PSLVERROR  in  1  slave error

Behaviour:
- One clock: io_apb_PCLK. Reset: io_apb_PRESET, asynchronous, active-high.
- Reset values: state=IDLE. PSEL, PENABLE, PWRITE, rsp_valid, rsp_error and rsp_timeout are 0. PADDR, PWDATA and rsp_rdata are 0. cmd_ready=1 after reset release.
- Reset mid-transfer: all outputs return to reset values immediately, with no completion response. The slave sees PSEL drop.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, combinational from state.
  - cmd_valid&cmd_ready at edge N: register addr, wdata and write into PADDR/PWDATA/PWRITE, then go to SETUP.
- SETUP (cycle N+1): PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS (cycle N+2 onward): PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE stay stable.
  - PREADY=1: capture PRDATA into rsp_rdata (reads only; writes give 0). rsp_error=PSLVERROR, rsp_timeout=0. Go to RESP.
  - PREADY=0: increment the wait counter.
  - Timeout: when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, abort. rsp_rdata=0, rsp_error=1, rsp_timeout=1, go to RESP.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1. Response fields hold stable until rsp_ready.
  - On rsp_valid&rsp_ready: go to IDLE and clear rsp_valid.
- Minimum latency: accept at N, rsp_valid at N+3. Minimum command interval is 4 cycles when rsp_ready is tied high.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Commands presented then are not accepted and must be held by the source.
- Wait counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to SETUP.
  - Saturates and never wraps. A PREADY arriving in the same cycle the timeout triggers wins: the transfer completes normally.
- PSEL is never high for more than one transfer. PENABLE is never high without PSEL.

Decomposition:
- Package apb3_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP};
  - ADDR_WIDTH/DATA_WIDTH defaults;
  - response flag bit positions.
- One sub-module, apb3_timeout_counter: clear, enable, saturating count, expired output. It is reusable by other bus masters.

Test Plan:
- Read, zero wait: cmd read addr 0x1004, slave PREADY=1 in first ACCESS with PRDATA=0xDEADBEEF -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_error=0.
- Write with 3 wait states: write 0x0008 data 0x12345678, PREADY low 3 cycles -> PADDR/PWDATA stable across 4 ACCESS cycles, rsp_valid at N+6, rsp_rdata=0.
- Slave error: read with PSLVERROR=1 at PREADY -> rsp_error=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles, PSEL drops, rsp_error=1, rsp_timeout=1. A same-cycle PREADY variant completes normally.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp fields stable and cmd_ready=0 throughout. A second cmd is accepted only the cycle after the handshake.
- Reset mid-ACCESS: assert io_apb_PRESET asynchronously -> PSEL/PENABLE/rsp_valid go to 0 without a clock edge, and cmd_ready=1 after release.
